// File: rtl/serial_pad_emulator.sv
// Multi-pad 4021-style serial controller emulator: synchronises core latch/pulse
// strobes, loads and shifts per-pad registers, and reports protocol state for debug.
module serial_pad_emulator #(
  parameter int unsigned NUM_PADS      = 2,
  parameter int unsigned BITS          = 8,
  parameter logic        FILL          = 1'b1,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter bit          SHIFT_ON_RISE = 1'b1,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [NUM_PADS*BITS-1:0] pad_buttons,
  input  logic [NUM_PADS-1:0]      pad_enable,
  input  logic                     latch,
  input  logic                     pulse,
  output logic [NUM_PADS-1:0]      data_out,
  output logic [1:0]               state,
  output logic [7:0]               read_count,
  output logic                     overrun
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOADING  = 2'd1,
    ST_SHIFTING = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [SYNC_STAGES-1:0]         latch_sync, pulse_sync;
  logic                           latch_prev, pulse_prev;
  logic                           latch_s, pulse_s;
  logic                           latch_fall, pulse_edge, shift_en;
  logic [NUM_PADS-1:0][BITS-1:0]  sr_q;
  logic [CNT_W-1:0]               read_count_q;
  logic                           overrun_q;

  // Strobe synchronisers plus previous-value registers for edge detection
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      latch_sync <= '0;
      pulse_sync <= '0;
      latch_prev <= 1'b0;
      pulse_prev <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch};
      pulse_sync <= {pulse_sync[SYNC_STAGES-2:0], pulse};
      latch_prev <= latch_s;
      pulse_prev <= pulse_s;
    end
  end

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign pulse_s    = pulse_sync[SYNC_STAGES-1];
  assign latch_fall = latch_prev & ~latch_s;
  assign pulse_edge = SHIFT_ON_RISE ? (pulse_s & ~pulse_prev) : (~pulse_s & pulse_prev);
  // Latch dominates: a pulse edge coinciding with latch high never shifts
  assign shift_en   = ~latch_s & pulse_edge & ((state_q == ST_SHIFTING) || (state_q == ST_DONE));

  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (latch_s) begin
      state_d = ST_LOADING;
    end else if (latch_fall && (state_q == ST_LOADING)) begin
      state_d = ST_SHIFTING;
    end else if (shift_en && (state_q == ST_SHIFTING) && (read_count_q == CNT_W'(BITS - 1))) begin
      state_d = ST_DONE;
    end
  end

  // Shift registers, read counter and overrun flag
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sr_q         <= '0;
      read_count_q <= '0;
      overrun_q    <= 1'b0;
    end else if (latch_s) begin
      for (int unsigned p = 0; p < NUM_PADS; p++) begin
        sr_q[p] <= pad_buttons[p*BITS +: BITS];
      end
      read_count_q <= '0;
      overrun_q    <= 1'b0;
    end else if (shift_en) begin
      for (int unsigned p = 0; p < NUM_PADS; p++) begin
        sr_q[p] <= {FILL, sr_q[p][BITS-1:1]};
      end
      if (read_count_q != {CNT_W{1'b1}}) read_count_q <= read_count_q + CNT_W'(1);
      if (state_q == ST_DONE) overrun_q <= 1'b1;
    end
  end

  // Disabled pads present the not-pressed level
  always_comb begin
    data_out = '0;
    for (int unsigned p = 0; p < NUM_PADS; p++) begin
      data_out[p] = (pad_enable[p] & sr_q[p][0]) ^ ACTIVE_LOW;
    end
  end

  assign state      = state_q;
  assign read_count = read_count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_pad_emulator.sv
// Directed bench for serial_pad_emulator: NES rise-shift, SNES and fall-shift
// builds share the core strobes; expectations are hand-computed constants.
module tb_serial_pad_emulator;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        latch, pulse;
  logic [1:0]  en;
  logic [15:0] btn8, btnf;
  logic [31:0] btn16;

  logic [1:0]  do8, do16, dof;
  logic [1:0]  st8, st16, stf;
  logic [7:0]  rc8, rc16, rcf;
  logic        ov8, ov16, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  serial_pad_emulator u_nes (
    .clk_sys(clk_sys), .reset(reset), .pad_buttons(btn8), .pad_enable(en),
    .latch(latch), .pulse(pulse), .data_out(do8), .state(st8),
    .read_count(rc8), .overrun(ov8)
  );

  serial_pad_emulator #(.BITS(16)) u_snes (
    .clk_sys(clk_sys), .reset(reset), .pad_buttons(btn16), .pad_enable(en),
    .latch(latch), .pulse(pulse), .data_out(do16), .state(st16),
    .read_count(rc16), .overrun(ov16)
  );

  serial_pad_emulator #(.SHIFT_ON_RISE(1'b0)) u_fall (
    .clk_sys(clk_sys), .reset(reset), .pad_buttons(btnf), .pad_enable(en),
    .latch(latch), .pulse(pulse), .data_out(dof), .state(stf),
    .read_count(rcf), .overrun(ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic do_pulse();
    pulse = 1'b1; cyc(4);
    pulse = 1'b0; cyc(4);
  endtask

  task automatic do_latch();
    latch = 1'b1; cyc(4);
    latch = 1'b0; cyc(4);
  endtask

  logic [7:0]  exp_nes;
  logic [15:0] exp_snes;

  initial begin
    reset = 1'b1; latch = 1'b0; pulse = 1'b0; en = 2'b11;
    btn8 = 16'h0005; btnf = 16'h0001; btn16 = 32'h8001_0000;
    exp_nes  = 8'b1111_1010;
    exp_snes = 16'h7FFE;
    cyc(3);
    check("rst_state", st8, 2'd0);
    check("rst_count", rc8, 8'd0);
    check("rst_ovr", ov8, 1'b0);
    check("rst_dout", do8, 2'b11);
    reset = 1'b0; cyc(2);

    // NES frame, active-low output sequence
    latch = 1'b1; cyc(4);
    check("load_state", st8, 2'd1);
    latch = 1'b0; cyc(4);
    check("shift_state", st8, 2'd2);
    check("shift_count0", rc8, 8'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("nes_bit%0d", i), do8[0], exp_nes[i]);
      do_pulse();
    end
    check("nes_count8", rc8, 8'd8);
    check("nes_done", st8, 2'd3);
    check("nes_no_ovr", ov8, 1'b0);
    check("nes_fill_dout", do8[0], 1'b0);
    do_pulse(); do_pulse();
    check("ovr_dout", do8[0], 1'b0);
    check("ovr_count10", rc8, 8'd10);
    check("ovr_set", ov8, 1'b1);

    // Relatch clears counters; pulses ignored while latch held
    latch = 1'b1; cyc(4);
    check("relatch_ovr", ov8, 1'b0);
    check("relatch_count", rc8, 8'd0);
    for (int i = 0; i < 3; i++) do_pulse();
    check("held_count", rc8, 8'd0);
    check("held_state", st8, 2'd1);
    btn8 = 16'h0004; cyc(3);
    check("transparent_load", do8[0], 1'b1);
    latch = 1'b0; cyc(4);

    // Latch and pulse rising on the same edge: load only
    btn8 = 16'h0005;
    latch = 1'b1; pulse = 1'b1; cyc(4);
    check("same_edge_count", rc8, 8'd0);
    check("same_edge_state", st8, 2'd1);
    check("same_edge_load", do8[0], 1'b0);
    latch = 1'b0; cyc(4);
    pulse = 1'b0; cyc(4);
    check("fall_no_shift_rise_build", rc8, 8'd0);

    // Falling-edge build shifts only on pulse fall
    do_latch();
    check("fall_bit0", dof[0], 1'b0);
    pulse = 1'b1; cyc(4);
    check("rise_build_shift", rc8, 8'd1);
    check("fall_build_no_shift", rcf, 8'd0);
    pulse = 1'b0; cyc(4);
    check("fall_build_shift", rcf, 8'd1);
    check("fall_bit1", dof[0], 1'b1);
    check("rise_build_hold", rc8, 8'd1);

    // SNES frame on pad 1, then disable mid-frame
    do_latch();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("snes_bit%0d", i), do16[1], exp_snes[i]);
      do_pulse();
    end
    check("snes_bit15", do16[1], exp_snes[15]);
    check("snes_count15", rc16, 8'd15);
    check("snes_not_done", st16, 2'd2);
    en = 2'b01; #1;
    check("snes_disable", do16[1], 1'b1);
    do_pulse();
    check("snes_done", st16, 2'd3);
    check("snes_count16", rc16, 8'd16);

    // Disabled NES pad masks pressed buttons
    btn8 = 16'hFF05;
    do_latch();
    check("nes_disabled_pad", do8[1], 1'b1);
    en = 2'b11; #1;
    check("nes_enabled_pad", do8[1], 1'b0);

    // Reset mid-frame, then pulses without a latch
    do_latch();
    for (int i = 0; i < 3; i++) do_pulse();
    check("pre_reset_count", rc8, 8'd3);
    reset = 1'b1; cyc(1);
    check("mid_rst_state", st8, 2'd0);
    check("mid_rst_count", rc8, 8'd0);
    check("mid_rst_dout", do8, 2'b11);
    check("mid_rst_ovr", ov8, 1'b0);
    reset = 1'b0; cyc(2);
    do_pulse(); do_pulse();
    check("idle_pulse_count", rc8, 8'd0);
    check("idle_pulse_state", st8, 2'd0);
    check("idle_pulse_dout", do8, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
